// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button arbiter (master) and the shared consumer (slave).
interface button_event_arbiter_if #(
    parameter int unsigned ID_W = 2
);
    logic            ev_valid;
    logic [ID_W-1:0] ev_id;
    logic            ev_ready;

    modport master (
        output ev_valid,
        output ev_id,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_id,
        output ev_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Queues one pending press per button and offers them round-robin to a single
// consumer over a valid/ready handshake, flagging presses that land on a queued event.
module button_event_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           pulse_in,
    input  logic                   ovf_clr,
    button_event_arbiter_if.master ev_if,
    output logic                   busy,
    output logic [N-1:0]           pend,
    output logic [N-1:0]           ovf
);

    localparam int unsigned GAP_W = 4;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [N-1:0]     pend_q,     pend_d;
    logic [N-1:0]     ovf_q,      ovf_d;
    logic [ID_W-1:0]  ptr_q,      ptr_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic             ev_valid_q, ev_valid_d;
    logic [ID_W-1:0]  ev_id_q,    ev_id_d;
    logic             busy_q,     busy_d;

    logic             accept;
    logic [N-1:0]     clr_vec;
    logic [N-1:0]     ovf_set;
    logic [N-1:0]     pend_rot;
    logic [ID_W:0]    pick_off;
    logic [ID_W:0]    pick_sum;
    logic [ID_W-1:0]  pick_id;
    logic             pick_found;

    // Round-robin pick: rotate pending vector so ptr sits at bit 0, take lowest set bit.
    always_comb begin
        pend_rot   = N'({pend_q, pend_q} >> ptr_q);
        pick_off   = '0;
        pick_found = |pend_q;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (pend_rot[k]) begin
                pick_off = (ID_W+1)'(k);
            end
        end
        pick_sum = {1'b0, ptr_q} + pick_off;
        if (pick_sum >= (ID_W+1)'(N)) begin
            pick_sum = pick_sum - (ID_W+1)'(N);
        end
        pick_id = pick_sum[ID_W-1:0];
    end

    // Handshake FSM next-state and registered outputs.
    always_comb begin
        state_d    = state_q;
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ptr_d      = ptr_q;
        gap_d      = gap_q;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                ev_valid_d = 1'b0;
                if (pick_found) begin
                    ev_id_d    = pick_id;
                    ev_valid_d = 1'b1;
                    state_d    = S_OFFER;
                end
            end
            S_OFFER: begin
                ev_valid_d = 1'b1;
                if (ev_if.ev_ready) begin
                    accept     = 1'b1;
                    ev_valid_d = 1'b0;
                    ptr_d      = (ev_id_q == ID_W'(N - 1)) ? '0 : ev_id_q + ID_W'(1);
                    if (GAP_CYC > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                ev_valid_d = 1'b0;
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                ev_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // A press arriving as its own event is accepted re-queues it instead of overflowing.
    always_comb begin
        clr_vec = accept ? (N'(1) << ev_id_q) : '0;
        ovf_set = pulse_in & pend_q & ~clr_vec;
        pend_d  = (pend_q & ~clr_vec) | pulse_in;
        ovf_d   = (ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            ovf_q      <= '0;
            ptr_q      <= '0;
            gap_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            busy_q     <= busy_d;
        end
    end

    assign ev_if.ev_valid = ev_valid_q;
    assign ev_if.ev_id    = ev_id_q;
    assign busy           = busy_q;
    assign pend           = pend_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: per-cycle vector table, then multi-cycle sequences
// with a scoreboard of expected event IDs checked on every accepted handshake.
module tb_button_event_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned GAP_CYC = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    pulse_in = '0;
    logic            ovf_clr = 1'b0;
    logic            busy;
    logic [N-1:0]    pend;
    logic [N-1:0]    ovf;

    button_event_arbiter_if #(.ID_W(ID_W)) ev_if ();

    button_event_arbiter #(.N(N), .ID_W(ID_W), .GAP_CYC(GAP_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .ovf_clr  (ovf_clr),
        .ev_if    (ev_if),
        .busy     (busy),
        .pend     (pend),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ID_W-1:0] exp_q[$];
    int              acc_t[$];

    typedef struct {
        logic         rst;
        logic [3:0]   pulse;
        logic         rdy;
        logic         clr;
        int           push;
        logic         valid;
        logic [1:0]   id;
        logic         busy;
        logic [3:0]   pend;
        logic [3:0]   ovf;
    } vec_t;

    vec_t vt[17];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected ID.
    always @(negedge clk) begin
        if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got id %0d expected none", ev_if.ev_id);
            end else begin
                chk("sb_id", 32'(ev_if.ev_id), 32'(exp_q.pop_front()));
                acc_t.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            step();
            n++;
        end
        chk({name, "_drain"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_if.ev_ready = 1'b0;

        //            rst   pulse    rdy   clr  push  valid id    busy  pend     ovf
        vt[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, -1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
        vt[1]  = '{1'b1, 4'b1111, 1'b1, 1'b0, -1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
        vt[2]  = '{1'b1, 4'b1111, 1'b1, 1'b0, -1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
        vt[3]  = '{1'b0, 4'b0100, 1'b1, 1'b0,  2, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000};
        vt[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, -1, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000};
        vt[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, -1, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000};
        vt[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, -1, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000};
        vt[7]  = '{1'b0, 4'b0010, 1'b0, 1'b0,  1, 1'b0, 2'd2, 1'b0, 4'b0010, 4'b0000};
        vt[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, -1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000};
        vt[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, -1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000};
        vt[10] = '{1'b0, 4'b0010, 1'b0, 1'b0, -1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010};
        vt[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, -1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000};
        vt[12] = '{1'b0, 4'b0010, 1'b0, 1'b1, -1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010};
        vt[13] = '{1'b0, 4'b0000, 1'b0, 1'b1, -1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000};
        vt[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, -1, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000};
        vt[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, -1, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000};
        vt[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, -1, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000};

        for (int i = 0; i < 17; i++) begin
            rst            = vt[i].rst;
            pulse_in       = vt[i].pulse;
            ev_if.ev_ready = vt[i].rdy;
            ovf_clr        = vt[i].clr;
            if (vt[i].push >= 0) exp_q.push_back(ID_W'(vt[i].push));
            step();
            chk($sformatf("vec%0d_valid", i), 32'(ev_if.ev_valid), 32'(vt[i].valid));
            chk($sformatf("vec%0d_id", i),    32'(ev_if.ev_id),    32'(vt[i].id));
            chk($sformatf("vec%0d_busy", i),  32'(busy),           32'(vt[i].busy));
            chk($sformatf("vec%0d_pend", i),  32'(pend),           32'(vt[i].pend));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf),            32'(vt[i].ovf));
        end
        ovf_clr = 1'b0;
        chk("table_sb_empty", 32'(exp_q.size()), 32'd0);

        // Round-robin from ptr=0, then wrap back to 0 after ID 3; back-to-back spacing.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ev_if.ev_ready = 1'b1;
        pulse_in = 4'b1011;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        acc_t.delete();
        step();
        pulse_in = '0;
        wait_drain("rr1");
        if (acc_t.size() >= 3) begin
            chk("rr_spacing_a", 32'(acc_t[1] - acc_t[0]), 32'(GAP_CYC + 2));
            chk("rr_spacing_b", 32'(acc_t[2] - acc_t[1]), 32'(GAP_CYC + 2));
        end else begin
            chk("rr_accept_count", 32'(acc_t.size()), 32'd3);
        end
        pulse_in = 4'b0011;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        step();
        pulse_in = '0;
        wait_drain("rr2");

        // Press on ID 3 in its own accept cycle re-queues it without overflow.
        ev_if.ev_ready = 1'b0;
        pulse_in = 4'b1000;
        exp_q.push_back(2'd3);
        step();
        pulse_in = '0;
        step();
        chk("rq_valid1", 32'(ev_if.ev_valid), 32'd1);
        chk("rq_id1",    32'(ev_if.ev_id),    32'd3);
        ev_if.ev_ready = 1'b1;
        pulse_in = 4'b1000;
        exp_q.push_back(2'd3);
        step();
        pulse_in = '0;
        ev_if.ev_ready = 1'b0;
        chk("rq_pend",   32'(pend),           32'b1000);
        chk("rq_ovf",    32'(ovf),            32'b0000);
        chk("rq_valid0", 32'(ev_if.ev_valid), 32'd0);
        step();
        chk("rq_gap_valid", 32'(ev_if.ev_valid), 32'd0);
        step();
        chk("rq_valid2", 32'(ev_if.ev_valid), 32'd1);
        chk("rq_id2",    32'(ev_if.ev_id),    32'd3);
        ev_if.ev_ready = 1'b1;
        wait_drain("rq");

        // Move ptr to 3 so a ptr that survives reset would change the grant order below.
        pulse_in = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        pulse_in = '0;
        wait_drain("prep");

        // Reset while offering ID 1 discards the event and returns ptr to 0.
        ev_if.ev_ready = 1'b0;
        pulse_in = 4'b0010;
        exp_q.push_back(2'd1);
        step();
        pulse_in = '0;
        step();
        chk("rm_valid1", 32'(ev_if.ev_valid), 32'd1);
        chk("rm_id1",    32'(ev_if.ev_id),    32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("rm_valid0", 32'(ev_if.ev_valid), 32'd0);
        chk("rm_pend0",  32'(pend),           32'd0);
        chk("rm_busy0",  32'(busy),           32'd0);
        ev_if.ev_ready = 1'b1;
        pulse_in = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        step();
        pulse_in = '0;
        step();
        chk("rm_valid2", 32'(ev_if.ev_valid), 32'd1);
        chk("rm_id2",    32'(ev_if.ev_id),    32'd1);
        wait_drain("rm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
